// File: rtl/data_tx_frame.sv
// UART response transmitter: latches addr/func/payload and sends a 6-byte frame (header, addr, func, payload hi/lo, checksum) 8N1, LSB first.
// Latency: start bit 1 cycle after accept; frame 60*CLKS_PER_BIT cycles; o_tx_done 1 cycle after the last stop bit. Requests while busy are dropped.
module data_tx_frame #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  HEADER       = 8'hAA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_tx_req,
    input  logic [7:0]  i_addr,
    input  logic [2:0]  i_func,
    input  logic [15:0] i_payload,
    output logic        o_tx_busy,
    output logic        o_tx_done,
    output logic        tx_pin
);

    localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [2:0]       byte_idx, byte_idx_nxt;
    logic [5:0][7:0]  frame;
    logic [7:0]       cur_byte;
    logic [7:0]       chk;
    logic             tx_nxt, busy_nxt, done_nxt;
    logic             accept, bit_end;

    always_comb begin
        accept   = (state == IDLE) && i_tx_req;
        bit_end  = (baud_cnt == CNT_MAX);
        cur_byte = frame[byte_idx];
        // Header is not part of the checksum; sum wraps at 8 bits.
        chk      = i_addr + {5'b0, i_func} + i_payload[15:8] + i_payload[7:0];
    end

    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        bit_idx_nxt  = bit_idx;
        byte_idx_nxt = byte_idx;
        tx_nxt       = tx_pin;
        busy_nxt     = o_tx_busy;
        done_nxt     = 1'b0;

        if (state != IDLE) begin
            baud_cnt_nxt = bit_end ? '0 : baud_cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                if (accept) begin
                    state_nxt    = START;
                    tx_nxt       = 1'b0;
                    busy_nxt     = 1'b1;
                    baud_cnt_nxt = '0;
                    bit_idx_nxt  = 3'd0;
                    byte_idx_nxt = 3'd0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = 3'd0;
                    tx_nxt      = cur_byte[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        tx_nxt      = cur_byte[bit_idx + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx < 3'd5) begin
                        // Next start bit follows the stop bit with no idle gap.
                        byte_idx_nxt = byte_idx + 3'd1;
                        state_nxt    = START;
                        tx_nxt       = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                        tx_nxt    = 1'b1;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            byte_idx  <= 3'd0;
            tx_pin    <= 1'b1;
            o_tx_busy <= 1'b0;
            o_tx_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            byte_idx  <= byte_idx_nxt;
            tx_pin    <= tx_nxt;
            o_tx_busy <= busy_nxt;
            o_tx_done <= done_nxt;
        end
    end

    // Frame contents only matter while busy, so no reset is needed.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            frame <= {chk, i_payload[7:0], i_payload[15:8], {5'b0, i_func}, i_addr, HEADER};
        end
    end

endmodule

// File: tb/tb_data_tx_frame.sv
// Bench for data_tx_frame: stimulus pushes expected frames, a line decoder pops and compares each received frame.
module tb_data_tx_frame;

    localparam int C    = 4;
    localparam int FLEN = 60 * C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_req;
    logic [7:0]  addr;
    logic [2:0]  func;
    logic [15:0] payload;
    logic        tx_busy, tx_done, tx_pin;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    logic [47:0] exp_q[$];
    bit          abort_flag = 1'b0;

    data_tx_frame #(.CLKS_PER_BIT(C), .HEADER(8'hAA)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_tx_req  (tx_req),
        .i_addr    (addr),
        .i_func    (func),
        .i_payload (payload),
        .o_tx_busy (tx_busy),
        .o_tx_done (tx_done),
        .tx_pin    (tx_pin)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line decoder: samples every cycle of a frame, then checks bit stability, framing, data and done timing.
    logic samp [0:FLEN-1];
    bit   mon_act = 1'b0;
    int   mon_cnt = 0;

    task automatic finish_frame();
        logic [47:0] got;
        logic [47:0] exp;
        bit          frame_ok;
        frame_ok = 1'b1;
        got      = '0;
        for (int j = 0; j < 60; j++)
            for (int k = 1; k < C; k++)
                if (samp[j*C+k] !== samp[j*C]) frame_ok = 1'b0;
        for (int b = 0; b < 6; b++) begin
            if (samp[(b*10)*C] !== 1'b0)   frame_ok = 1'b0;
            if (samp[(b*10+9)*C] !== 1'b1) frame_ok = 1'b0;
            for (int i = 0; i < 8; i++) got[b*8+i] = samp[(b*10+1+i)*C];
        end
        check("frame_shape", {63'b0, frame_ok}, 64'd1);
        check("done_timing", {62'b0, tx_done, tx_busy}, 64'b10);
        if (exp_q.size() == 0) begin
            check("unexpected_frame", {16'b0, got}, 64'hDEAD);
        end else begin
            exp = exp_q.pop_front();
            check("frame_bytes", {16'b0, got}, {16'b0, exp});
        end
    endtask

    always @(negedge clk) begin
        if (tx_done) n_done++;
        if (!mon_act) begin
            if (rst_n === 1'b1 && tx_pin === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
                samp[0] = tx_pin;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt < FLEN) begin
                samp[mon_cnt] = tx_pin;
            end else begin
                mon_act = 1'b0;
                if (abort_flag) abort_flag = 1'b0;
                else finish_frame();
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [2:0] f, input logic [15:0] p, input logic [47:0] exp);
        @(negedge clk);
        addr = a; func = f; payload = p; tx_req = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        tx_req = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < FLEN + 60; i++) begin
            @(negedge clk);
            if (tx_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int errs;
        rst_n = 1'b0; tx_req = 1'b0; addr = '0; func = '0; payload = '0;
        repeat (3) @(negedge clk);
        check("reset_tx",   {63'b0, tx_pin},  64'd1);
        check("reset_busy", {63'b0, tx_busy}, 64'd0);
        check("reset_done", {63'b0, tx_done}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame plus exact latency / busy window / done cycle.
        send(8'h01, 3'd2, 16'h1234, 48'h49_34_12_02_01_AA);
        check("start_latency_tx",   {63'b0, tx_pin},  64'd0);
        check("start_latency_busy", {63'b0, tx_busy}, 64'd1);
        errs = 0;
        repeat (FLEN - 1) begin
            @(negedge clk);
            if (!tx_busy || tx_done) errs++;
        end
        check("busy_window", errs, 0);
        @(negedge clk);
        check("done_at_241", {62'b0, tx_done, tx_busy}, 64'b10);
        repeat (5) @(negedge clk);

        // Checksum wrap: 0x304 -> 0x04.
        send(8'hFF, 3'd7, 16'hFFFF, 48'h04_FF_FF_07_FF_AA);
        wait_done();
        repeat (3) @(negedge clk);

        // Request mid-frame with different inputs must be ignored.
        send(8'h5A, 3'd3, 16'hC3A5, 48'hC5_A5_C3_03_5A_AA);
        repeat (49) @(negedge clk);
        addr = 8'h11; func = 3'd1; payload = 16'h2222; tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);

        // Held request: back-to-back frames with one idle-high cycle between.
        @(negedge clk);
        addr = 8'h80; func = 3'd1; payload = 16'h0080; tx_req = 1'b1;
        exp_q.push_back(48'h01_80_00_01_80_AA);
        exp_q.push_back(48'h01_80_00_01_80_AA);
        wait_done();
        check("b2b_gap_tx", {63'b0, tx_pin}, 64'd1);
        @(negedge clk);
        check("b2b_restart", {61'b0, tx_pin, tx_busy, tx_done}, 64'b010);
        tx_req = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);

        // Reset during byte 2 aborts the frame; a fresh frame then goes out cleanly.
        send(8'h77, 3'd5, 16'hABCD, 48'h0);
        repeat (89) @(negedge clk);
        rst_n = 1'b0;
        abort_flag = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("abort_state", {61'b0, tx_pin, tx_busy, tx_done}, 64'b100);
        rst_n = 1'b1;
        repeat (70 * C) @(negedge clk);
        send(8'h3C, 3'd4, 16'h0F0F, 48'h5E_0F_0F_04_3C_AA);
        wait_done();
        repeat (5) @(negedge clk);

        check("done_pulse_count", n_done, 6);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
